// File: rtl/mac_acc.sv
// rtl/mac_acc.sv - two-stage framed multiply-accumulate with sticky overflow and optional saturation
module mac_acc #(
    parameter int DW     = 16,
    parameter int AW     = 36,
    parameter int SIGNED = 1,
    parameter int SAT    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          sof,
    input  logic          eof,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          out_valid,
    output logic [AW-1:0] c,
    output logic          ovf
);

    localparam int PW = 2 * DW;

    logic          a_sgn;
    logic          b_sgn;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod_d;
    logic [PW-1:0] prod_q;
    logic          s1_valid_q;
    logic          s1_sof_q;
    logic          s1_eof_q;

    logic          p_sgn;
    logic [AW:0]   prod_x;
    logic [AW:0]   base_x;
    logic [AW:0]   sum_x;
    logic          ovf_now;
    logic [AW-1:0] sat_val;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] acc_q;
    logic          acc_ovf_d;
    logic          acc_ovf_q;

    logic          out_valid_q;
    logic [AW-1:0] c_q;
    logic          ovf_q;

    // Extending both operands to the product width lets one unsigned
    // multiply produce the correct two's-complement product as well.
    assign a_sgn  = (SIGNED != 0) && a[DW-1];
    assign b_sgn  = (SIGNED != 0) && b[DW-1];
    assign a_ext  = {{DW{a_sgn}}, a};
    assign b_ext  = {{DW{b_sgn}}, b};
    assign prod_d = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            s1_sof_q   <= in_valid & sof;
            s1_eof_q   <= in_valid & eof;
            if (in_valid) begin
                prod_q <= prod_d;
            end
        end
    end

    // One guard bit above AW holds the exact sum, so overflow is a plain bit test.
    assign p_sgn   = (SIGNED != 0) && prod_q[PW-1];
    assign prod_x  = {{(AW + 1 - PW){p_sgn}}, prod_q};
    assign base_x  = s1_sof_q ? '0 : {(SIGNED != 0) && acc_q[AW-1], acc_q};
    assign sum_x   = base_x + prod_x;
    assign ovf_now = (SIGNED != 0) ? (sum_x[AW] != sum_x[AW-1]) : sum_x[AW];

    always_comb begin
        sat_val = '1;
        if (SIGNED != 0) begin
            sat_val = sum_x[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
        end
    end

    assign acc_d     = (ovf_now && (SAT != 0)) ? sat_val : sum_x[AW-1:0];
    assign acc_ovf_d = (!s1_sof_q && acc_ovf_q) || ovf_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q & s1_eof_q;
            if (s1_valid_q) begin
                acc_q     <= acc_d;
                acc_ovf_q <= acc_ovf_d;
                if (s1_eof_q) begin
                    c_q   <= acc_d;
                    ovf_q <= acc_ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_acc.sv
// tb/tb_mac_acc.sv - randomized and directed checks of mac_acc against a queue-based frame model
module tb_mac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        sof;
    logic        eof;
    logic [15:0] a;
    logic [15:0] b;

    logic        ov0, ov1, ov2;
    logic [35:0] c0;
    logic [31:0] c1, c2;
    logic        f0, f1, f2;

    always #5 clk = ~clk;

    mac_acc u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .eof(eof),
        .a(a), .b(b), .out_valid(ov0), .c(c0), .ovf(f0)
    );

    mac_acc #(.DW(16), .AW(32), .SIGNED(1), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .eof(eof),
        .a(a), .b(b), .out_valid(ov1), .c(c1), .ovf(f1)
    );

    mac_acc #(.DW(16), .AW(32), .SIGNED(1), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .eof(eof),
        .a(a), .b(b), .out_valid(ov2), .c(c2), .ovf(f2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: accepted samples wait in a queue until the edge they take effect.
    typedef struct {
        longint prod;
        bit     sof;
        bit     eof;
        int     due;
    } samp_t;

    samp_t  pend[$];
    int     aw_of[3]  = '{36, 32, 32};
    bit     sat_of[3] = '{1'b0, 1'b1, 1'b0};
    longint acc[3];
    bit     fovf[3];
    longint ec[3];
    bit     eo[3];
    bit     exp_ov;
    int     cyc = 0;

    int                 pulses[3];
    logic signed [63:0] last_c[3];
    logic signed [63:0] prev_c[3];
    bit                 last_f[3];
    bit                 prev_f[3];
    int                 last_cyc[3];
    int                 prev_cyc[3];

    task automatic apply(input int i, input samp_t s);
        longint m, mx, mn, sum;
        m  = 64'sd1 <<< aw_of[i];
        mx = (m >>> 1) - 1;
        mn = -(m >>> 1);
        if (s.sof) begin
            acc[i]  = s.prod;
            fovf[i] = 1'b0;
        end else begin
            sum = acc[i] + s.prod;
            if (sum > mx || sum < mn) begin
                fovf[i] = 1'b1;
                if (sat_of[i]) sum = (sum > mx) ? mx : mn;
                else if (sum > mx) sum = sum - m;
                else sum = sum + m;
            end
            acc[i] = sum;
        end
    endtask

    task automatic model_edge();
        samp_t s;
        cyc++;
        exp_ov = 1'b0;
        if (rst) begin
            pend.delete();
            for (int i = 0; i < 3; i++) begin
                acc[i] = 0; fovf[i] = 1'b0; ec[i] = 0; eo[i] = 1'b0;
            end
            return;
        end
        while (pend.size() > 0 && pend[0].due == cyc) begin
            s = pend.pop_front();
            for (int i = 0; i < 3; i++) begin
                apply(i, s);
                if (s.eof) begin
                    ec[i] = acc[i];
                    eo[i] = fovf[i];
                end
            end
            if (s.eof) exp_ov = 1'b1;
        end
        if (in_valid) begin
            s.prod = longint'($signed(a)) * longint'($signed(b));
            s.sof  = sof;
            s.eof  = eof;
            s.due  = cyc + 1;
            pend.push_back(s);
        end
    endtask

    task automatic rec(input int i, input logic signed [63:0] cv, input bit fv);
        pulses[i]++;
        prev_c[i]   = last_c[i];
        prev_f[i]   = last_f[i];
        prev_cyc[i] = last_cyc[i];
        last_c[i]   = cv;
        last_f[i]   = fv;
        last_cyc[i] = cyc;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) begin
            pulses[i] = 0; last_c[i] = 0; prev_c[i] = 0;
            last_f[i] = 1'b0; prev_f[i] = 1'b0; last_cyc[i] = 0; prev_cyc[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("u_def.out_valid", ov0, exp_ov);
        check("u_def.c", $signed(c0), ec[0]);
        check("u_def.ovf", f0, eo[0]);
        check("u_sat.out_valid", ov1, exp_ov);
        check("u_sat.c", $signed(c1), ec[1]);
        check("u_sat.ovf", f1, eo[1]);
        check("u_wrap.out_valid", ov2, exp_ov);
        check("u_wrap.c", $signed(c2), ec[2]);
        check("u_wrap.ovf", f2, eo[2]);
        if (ov0) rec(0, $signed(c0), f0);
        if (ov1) rec(1, $signed(c1), f1);
        if (ov2) rec(2, $signed(c2), f2);
    endtask

    task automatic send(input int av, input int bv, input bit s, input bit e);
        in_valid = 1'b1;
        a = 16'(av); b = 16'(bv); sof = s; eof = e;
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; sof = 1'b0; eof = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    int acc_cyc;

    initial begin
        rst = 1'b1; in_valid = 1'b1; sof = 1'b1; eof = 1'b1; a = 16'h1234; b = 16'h4321;
        clear_stats();
        tick();
        tick();
        check("reset_c", $signed(c0), 0);
        check("reset_out_valid", ov0, 0);
        rst = 1'b0;
        idle(2);

        // Twelve-sample frame, default parameters
        clear_stats();
        for (int i = 1; i <= 12; i++) begin
            send(i, 15, i == 1, i == 12);
            if (i == 12) acc_cyc = cyc;
        end
        idle(3);
        check("s1_c", last_c[0], 1170);
        check("s1_ovf", last_f[0], 0);
        check("s1_pulses", pulses[0], 1);
        check("s1_latency", last_cyc[0] - acc_cyc, 1);

        // Negative frame then back-to-back single-sample frame
        clear_stats();
        for (int i = 0; i < 4; i++) send(-3, 5, i == 0, i == 3);
        send(7, 7, 1'b1, 1'b1);
        idle(3);
        check("s2_first_c", prev_c[0], -60);
        check("s2_second_c", last_c[0], 49);
        check("s2_spacing", last_cyc[0] - prev_cyc[0], 1);
        check("s2_pulses", pulses[0], 2);

        // in_valid toggling with framing strobes on idle cycles
        clear_stats();
        for (int i = 1; i <= 4; i++) begin
            send(i, 2, i == 1, i == 4);
            if (i < 4) begin
                in_valid = 1'b0; sof = 1'b1; eof = 1'b1;
                a = 16'($urandom); b = 16'($urandom);
                tick();
            end
        end
        idle(3);
        check("s3_c", last_c[0], 20);
        check("s3_pulses", pulses[0], 1);

        // Overflow: saturating and wrapping 32-bit accumulators
        clear_stats();
        for (int i = 0; i < 3; i++) send(32767, 32767, i == 0, i == 2);
        send(1, 1, 1'b1, 1'b1);
        idle(3);
        check("s4_sat_c", prev_c[1], 2147483647);
        check("s4_sat_ovf", prev_f[1], 1);
        check("s4_sat_next_c", last_c[1], 1);
        check("s4_sat_next_ovf", last_f[1], 0);
        check("s5_wrap_c", prev_c[2], -1073938429);
        check("s5_wrap_ovf", prev_f[2], 1);
        check("s4_wide_c", prev_c[0], 64'sd3221028867);
        check("s4_wide_ovf", prev_f[0], 0);

        // Reset mid-frame aborts it
        clear_stats();
        for (int i = 1; i <= 3; i++) send(i + 4, 9, i == 1, 1'b0);
        rst = 1'b1; in_valid = 1'b1; sof = 1'b0; eof = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);
        check("s6_pulses_after_rst", pulses[0], 0);
        check("s6_c_after_rst", $signed(c0), 0);
        check("s6_ovf_after_rst", f0, 0);
        send(2, 3, 1'b1, 1'b0);
        send(2, 3, 1'b0, 1'b1);
        idle(3);
        check("s6_next_c", last_c[0], 12);
        check("s6_next_pulses", pulses[0], 1);

        // Randomized traffic, biased toward extreme operands to provoke overflow
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 149) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            sof      = ($urandom_range(0, 5) == 0);
            eof      = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom_range(0, 1) ? 16'h7fff : 16'h8000;
                b = $urandom_range(0, 1) ? 16'h7fff : 16'h8000;
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
            tick();
        end
        rst = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_acc.md
MAC_ACC -- requirements
Module: mac_acc

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter DW, default 16, SHALL set the width of operands a and b.
REQ-003 Parameter AW, default 36, SHALL set the accumulator and result width; AW >= 2*DW is required.
REQ-004 Parameter SIGNED, default 1, SHALL select two's-complement operands (1) or unsigned operands (0).
REQ-005 Parameter SAT, default 0, SHALL select saturating accumulation (1) or wrap-around accumulation (0).
REQ-006 Port clk, input, 1 bit: the rising-edge clock for all state.
REQ-007 Port rst, input, 1 bit: the synchronous active-high reset.
REQ-008 Port in_valid, input, 1 bit: the sample on a and b is accepted this cycle.
REQ-009 Port sof, input, 1 bit: the accepted sample starts a new frame; it is qualified by in_valid.
REQ-010 Port eof, input, 1 bit: the accepted sample ends the frame; it is qualified by in_valid.
REQ-011 Port a, input, DW bits: operand A.
REQ-012 Port b, input, DW bits: operand B.
REQ-013 Port out_valid, output, 1 bit: a one-cycle pulse marking a valid c and ovf.
REQ-014 Port c, output, AW bits: the frame sum of a*b.
REQ-015 Port ovf, output, 1 bit: at least one accumulation in the frame overflowed AW.

Function
REQ-016 Stage 1 SHALL register the full-precision product a*b (2*DW bits, signedness per SIGNED) together with sof, eof and in_valid at the edge where in_valid=1.
REQ-017 Stage 2 SHALL update the accumulator at the next edge; for a staged sample with sof=1, acc SHALL be set to the sign- or zero-extended product, otherwise acc SHALL be set to acc + product.
REQ-018 A cycle with in_valid=0 SHALL leave the accumulator, the overflow flag and the outputs unchanged; sof and eof SHALL be ignored in that cycle.
REQ-019 When the staged sample has eof=1, c SHALL take the updated acc value and out_valid SHALL be 1 for exactly one cycle, two clk edges after the eof sample is accepted.
REQ-020 c SHALL hold its value between out_valid pulses.
REQ-021 A sample with sof=1 and eof=1 SHALL form a one-sample frame, giving c = a*b.
REQ-022 Back-to-back frames SHALL be supported at full rate: eof on cycle n and sof on cycle n+1 SHALL need no idle cycle.
REQ-023 Samples accepted after reset and before any sof SHALL accumulate onto acc=0.
REQ-024 A sof arriving mid-frame without a preceding eof SHALL discard the open frame without producing an out_valid pulse.
REQ-025 Overflow SHALL be detected when the exact sum falls outside the AW range: signed range for SIGNED=1, 0..2^AW-1 for SIGNED=0.
REQ-026 With SAT=0, overflow SHALL wrap modulo 2^AW.
REQ-027 With SAT=1, overflow SHALL clamp acc to the maximum or minimum AW value, and further accumulation SHALL continue from the clamped value.
REQ-028 The overflow flag SHALL be sticky within a frame, SHALL be cleared by sof, and SHALL be presented on ovf together with out_valid.

Reset
REQ-029 While rst=1, out_valid, c, ovf, acc and all pipeline valid, sof and eof flags SHALL be 0 from the first edge.
REQ-030 A reset asserted mid-frame SHALL abort the frame; no out_valid pulse SHALL be produced for the samples already accepted.
REQ-031 Inputs SHALL be ignored during any cycle in which rst=1.

Verification
REQ-032 The bench SHALL cover: defaults, 12 samples a=1..12, b=15, sof on sample 1, eof on sample 12 -> a single out_valid pulse 2 edges after sample 12, c=1170, ovf=0.
REQ-033 The bench SHALL cover: SIGNED=1, 4 samples a=-3, b=5, sof and eof framing, then immediately the next frame a=7, b=7 with sof=eof=1 -> c=-60, then c=49 on consecutive pulses one cycle apart.
REQ-034 The bench SHALL cover: in_valid toggling 1/0 across the frame a=1..4, b=2, with sof and eof asserted on idle cycles as well -> only the valid cycles count, c=20, exactly one pulse.
REQ-035 The bench SHALL cover: DW=16, AW=32, SAT=1, three samples a=b=32767 -> c=2147483647 and ovf=1; the next frame a=1, b=1 -> c=1 and ovf=0.
REQ-036 The bench SHALL cover: the same stimulus with SAT=0 -> c=-1073938429 and ovf=1.
REQ-037 The bench SHALL cover: rst pulsed after sample 3 of a 5-sample frame -> no out_valid pulse; outputs are 0; the next full frame a=2, b=3, 2 samples, gives c=12.
